// File: rtl/mux4_rr_arbiter_if.sv
// Bus for the 4:1 round-robin arbiter: requester side plus valid/ready output channel.
// The lock vector is present only when ARB_LOCK_EN is defined.
interface mux4_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          req;
  logic [4*DATA_W-1:0] data_in;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [3:0]          gnt;
  logic [1:0]          sel;
`ifdef ARB_LOCK_EN
  logic [3:0]          lock;

  modport master (
    input  req, data_in, out_ready, lock,
    output out_valid, out_data, gnt, sel
  );

  modport slave (
    output req, data_in, out_ready, lock,
    input  out_valid, out_data, gnt, sel
  );
`else
  modport master (
    input  req, data_in, out_ready,
    output out_valid, out_data, gnt, sel
  );

  modport slave (
    output req, data_in, out_ready,
    input  out_valid, out_data, gnt, sel
  );
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select, with a per-grant burst limit.
// Optional ARB_LOCK_EN: a locked grantee keeps its grant past the burst limit.
module mux4_rr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mux4_rr_arbiter_if.master bus
);

  localparam int unsigned    CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [1:0]    sel, sel_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [3:0]    gnt, gnt_nx;
  logic [CW-1:0] beat_cnt, cnt_nx;

  logic          found;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          hold;

  // Scan ptr, ptr+1, ... (mod 4) for the first active request.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign hold = bus.lock[sel];
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      gnt      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      gnt      <= gnt_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    cnt_nx   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          sel_nx   = pick;
          gnt_nx   = 4'b0001 << pick;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[sel]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          ptr_nx   = sel + 2'd1;
        end else if (bus.out_ready) begin
          if (beat_cnt == LAST) begin
            // A locked grantee saturates at the last beat instead of releasing.
            if (!hold) begin
              state_nx = IDLE;
              gnt_nx   = '0;
              ptr_nx   = sel + 2'd1;
            end
          end else begin
            cnt_nx = beat_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    bus.gnt       = gnt;
    bus.sel       = sel;
    bus.out_valid = (state == GRANT) && bus.req[sel];
    bus.out_data  = bus.data_in[sel*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected grantee ids are queued as stimulus is
// driven and popped by a beat monitor; define ARB_LOCK_EN to include the lock scenario.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   exp_q[$];

  mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fresh per-cycle data so each beat carries a distinct word per requester.
  task automatic set_data();
    for (int i = 0; i < 4; i++)
      bus.data_in[i*DW +: DW] = {4'(i), 4'(cyc)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    set_data();
  endtask

  task automatic push(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(id);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'd1, 32'd0);
      end else begin
        int id;
        id = exp_q.pop_front();
        chk("beat_sel",  32'(bus.sel), 32'(id));
        chk("beat_gnt",  32'(bus.gnt), 32'(4'b0001 << id));
        chk("beat_data", 32'(bus.out_data), 32'(bus.data_in[id*DW +: DW]));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
`ifdef ARB_LOCK_EN
    bus.lock      = 4'b0000;
`endif
    set_data();

    // Reset with all requests pending
    tick();
    tick();
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_sel",   32'(bus.sel), 32'h0);

    // Full round robin: 0,1,2,3,0 with 4 beats each and one bubble
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 32'(bus.gnt), 32'h0);
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_gnt",   32'(bus.gnt), 32'(4'b0001 << (g % 4)));
        chk("rr_valid", 32'(bus.out_valid), 32'h1);
        tick();
      end
      chk("rr_bubble_gnt",   32'(bus.gnt), 32'h0);
      chk("rr_bubble_valid", 32'(bus.out_valid), 32'h0);
      tick();
    end
    chk("rr_next_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    #1;
    chk("withdraw_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("withdraw_gnt", 32'(bus.gnt), 32'h0);
    chk("withdraw_ptr", 32'(dut.ptr), 32'h2);

    // Stall: single requester 2 with out_ready low
    bus.req       = 4'b0100;
    bus.out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_gnt",   32'(bus.gnt), 32'h4);
      chk("stall_sel",   32'(bus.sel), 32'h2);
      chk("stall_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_cnt",   32'(dut.beat_cnt), 32'h0);
      tick();
    end
    bus.req = 4'b0000;
    tick();
    chk("stall_rel_ptr", 32'(dut.ptr), 32'h3);

    // Requester 1 withdraws after 2 beats; then 3 wins over 0
    bus.req       = 4'b0010;
    bus.out_ready = 1'b1;
    push(1, 2);
    tick();
    chk("wd_gnt", 32'(bus.gnt), 32'h2);
    tick();
    tick();
    bus.req = 4'b0000;
    #1;
    chk("wd_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("wd_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("wd_rel_ptr", 32'(dut.ptr), 32'h2);
    bus.req = 4'b1001;
    push(3, 2);
    tick();
    chk("wrap_sel", 32'(bus.sel), 32'h3);
    chk("wrap_gnt", 32'(bus.gnt), 32'h8);
    tick();
    tick();
    chk("mid_cnt", 32'(dut.beat_cnt), 32'h2);

    // Asynchronous reset in the middle of the burst
    rst = 1'b1;
    #1;
    chk("async_gnt",   32'(bus.gnt), 32'h0);
    chk("async_valid", 32'(bus.out_valid), 32'h0);
    chk("async_sel",   32'(bus.sel), 32'h0);
    tick();
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("after_rst_gnt", 32'(bus.gnt), 32'h1);
    chk("after_rst_sel", 32'(bus.sel), 32'h0);
    bus.req = 4'b0000;
    tick();
    chk("after_rst_rel", 32'(bus.gnt), 32'h0);

`ifdef ARB_LOCK_EN
    // Locked requester 0 holds for 10 beats, releases on the 11th
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.req       = 4'b0011;
    bus.lock      = 4'b0001;
    bus.out_ready = 1'b1;
    push(0, 11);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("lock_gnt", 32'(bus.gnt), 32'h1);
      tick();
    end
    chk("lock_cnt_sat", 32'(dut.beat_cnt), 32'h3);
    bus.lock = 4'b0000;
    #1;
    chk("lock_last_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("lock_bubble", 32'(bus.gnt), 32'h0);
    bus.out_ready = 1'b0;
    tick();
    chk("lock_next_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
